// File: rtl/cordiv_regen_param.sv
// Correlated stochastic divider: saturating-counter bitstream regeneration
// feeding a CORDIV core with a selectable quotient history tap.
module cordiv_regen_param #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned HIST_DEPTH = 4,
  parameter int unsigned SEL_W      = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             regen_en,
  input  logic [CNT_W-1:0] randnum,
  input  logic [SEL_W-1:0] sel,
  input  logic             dividend,
  input  logic             divisor,
  output logic             quotient,
  output logic [CNT_W-1:0] dividend_cnt,
  output logic [CNT_W-1:0] divisor_cnt
);

  // Counters start at mid-scale (probability 0.5); history starts as 1,0,1,0...
  localparam logic [CNT_W-1:0]      CNT_INIT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [HIST_DEPTH-1:0] HIST_INIT = {(HIST_DEPTH/2){2'b01}};

  logic [HIST_DEPTH-1:0] hist;
  logic [HIST_DEPTH-1:0] hist_shift_c;
  logic                  dvd_r_c;
  logic                  dvs_r_c;
  logic                  q_next_c;
  logic [CNT_W-1:0]      dividend_cnt_nxt_c;
  logic [CNT_W-1:0]      divisor_cnt_nxt_c;

  // Regenerated streams use the pre-update counter values
  always_comb begin
    dvd_r_c = dividend;
    dvs_r_c = divisor;
    if (regen_en) begin
      dvd_r_c = (dividend_cnt >= randnum);
      dvs_r_c = (divisor_cnt >= randnum);
    end
  end

  // CORDIV core: pass dividend when divisor fires, else replay a past quotient
  always_comb begin
    q_next_c     = dvs_r_c ? dvd_r_c : hist[sel];
    hist_shift_c = {hist[HIST_DEPTH-2:0], q_next_c};
  end

  // Saturating up/down counter updates
  always_comb begin
    dividend_cnt_nxt_c = dividend_cnt;
    divisor_cnt_nxt_c  = divisor_cnt;
    if (dividend) begin
      if (dividend_cnt != CNT_MAX) dividend_cnt_nxt_c = dividend_cnt + CNT_W'(1);
    end else begin
      if (dividend_cnt != CNT_ZERO) dividend_cnt_nxt_c = dividend_cnt - CNT_W'(1);
    end
    if (divisor) begin
      if (divisor_cnt != CNT_MAX) divisor_cnt_nxt_c = divisor_cnt + CNT_W'(1);
    end else begin
      if (divisor_cnt != CNT_ZERO) divisor_cnt_nxt_c = divisor_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_cnt <= CNT_INIT;
      divisor_cnt  <= CNT_INIT;
    end else if (clr) begin
      dividend_cnt <= CNT_INIT;
      divisor_cnt  <= CNT_INIT;
    end else if (en) begin
      dividend_cnt <= dividend_cnt_nxt_c;
      divisor_cnt  <= divisor_cnt_nxt_c;
    end
  end

  // History advances only on divisor-1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= HIST_INIT;
    end else if (clr) begin
      hist <= HIST_INIT;
    end else if (en && dvs_r_c) begin
      hist <= hist_shift_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient <= 1'b0;
    end else if (clr) begin
      quotient <= 1'b0;
    end else if (en) begin
      quotient <= q_next_c;
    end
  end

endmodule

// File: tb/tb_cordiv_regen_param.sv
// Randomized self-checking bench for cordiv_regen_param against a
// cycle-level behavioural model (default instance) plus a wide/deep instance.
module tb_cordiv_regen_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr, regen_en, dividend, divisor;
  logic [7:0] randnum;
  logic [1:0] sel;
  logic       quotient;
  logic [7:0] dividend_cnt, divisor_cnt;

  logic       en2, clr2, regen_en2, dividend2, divisor2;
  logic [9:0] randnum2;
  logic [2:0] sel2;
  logic       quotient2;
  logic [9:0] dividend_cnt2, divisor_cnt2;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state (default instance)
  int       m_dcnt, m_vcnt;
  bit [3:0] m_hist;
  bit       m_q;

  always #5 clk = ~clk;

  cordiv_regen_param dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .regen_en(regen_en),
    .randnum(randnum), .sel(sel), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .dividend_cnt(dividend_cnt), .divisor_cnt(divisor_cnt)
  );

  cordiv_regen_param #(.CNT_W(10), .HIST_DEPTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr2), .regen_en(regen_en2),
    .randnum(randnum2), .sel(sel2), .dividend(dividend2), .divisor(divisor2),
    .quotient(quotient2), .dividend_cnt(dividend_cnt2), .divisor_cnt(divisor_cnt2)
  );

  task automatic model_reset();
    m_dcnt = 128;
    m_vcnt = 128;
    m_hist = 4'b0101;
    m_q    = 1'b0;
  endtask

  function automatic int sat_step(input int v, input bit up);
    if (up) return (v < 255) ? v + 1 : 255;
    return (v > 0) ? v - 1 : 0;
  endfunction

  // Drive one cycle, advance the model, wait for the edge and settle
  task automatic step(input bit e, input bit c, input bit rg, input logic [7:0] rn,
                      input logic [1:0] s, input bit a, input bit b);
    bit dr, vr, qn;
    en = e; clr = c; regen_en = rg; randnum = rn; sel = s; dividend = a; divisor = b;
    if (c) begin
      model_reset();
    end else if (e) begin
      dr = rg ? (m_dcnt >= int'(rn)) : a;
      vr = rg ? (m_vcnt >= int'(rn)) : b;
      qn = vr ? dr : m_hist[s];
      if (vr) begin
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = qn;
      end
      m_q    = qn;
      m_dcnt = sat_step(m_dcnt, a);
      m_vcnt = sat_step(m_vcnt, b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 30; k++)
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom));
    n_vec++;
    if (quotient !== m_q || dividend_cnt !== 8'(m_dcnt) || divisor_cnt !== 8'(m_vcnt)) begin
      n_err++;
      $display("FAIL pre_reset: got q=%0b d=%0h v=%0h, want q=%0b d=%0h v=%0h",
               quotient, dividend_cnt, divisor_cnt, m_q, m_dcnt, m_vcnt);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (quotient !== 1'b0 || dividend_cnt !== 8'h80 || divisor_cnt !== 8'h80 ||
        dut.hist !== 4'b0101 || quotient2 !== 1'b0 || dividend_cnt2 !== 10'h200 ||
        divisor_cnt2 !== 10'h200 || dut2.hist !== 8'b0101_0101) begin
      n_err++;
      $display("FAIL async_reset: got q=%0b d=%0h v=%0h h=%b q2=%0b d2=%0h v2=%0h h2=%b, want 0 80 80 0101 0 200 200 01010101",
               quotient, dividend_cnt, divisor_cnt, dut.hist,
               quotient2, dividend_cnt2, divisor_cnt2, dut2.hist);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      n_vec++;
      if (quotient !== 1'b0 || dividend_cnt !== 8'h80 || divisor_cnt !== 8'h80 ||
          dut.hist !== 4'b0101) begin
        n_err++;
        $display("FAIL hold_after_reset[%0d]: got q=%0b d=%0h v=%0h h=%b, want 0 80 80 0101",
                 k, quotient, dividend_cnt, divisor_cnt, dut.hist);
      end
    end
  endtask

  task automatic test_bypass();
    step(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'($urandom), 2'($urandom), 1'b1, 1'b1);
      n_vec++;
      if (quotient !== 1'b1 || dividend_cnt !== 8'(129 + k) || divisor_cnt !== 8'(129 + k)) begin
        n_err++;
        $display("FAIL bypass[%0d]: got q=%0b d=%0h v=%0h, want q=1 d=v=%0h",
                 k, quotient, dividend_cnt, divisor_cnt, 129 + k);
      end
    end
    n_vec++;
    if (dut.hist !== 4'b1111) begin
      n_err++;
      $display("FAIL bypass_hist: got %b want 1111", dut.hist);
    end
  endtask

  task automatic test_hist_sel();
    bit       want [2];
    logic [1:0] taps [2];
    want[0] = 1'b1; taps[0] = 2'd2;
    want[1] = 1'b0; taps[1] = 2'd1;
    for (int t = 0; t < 2; t++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        step(1'b1, 1'b0, 1'b0, 8'($urandom), taps[t], 1'($urandom), 1'b0);
        n_vec++;
        if (quotient !== want[t] || dut.hist !== 4'b0101 || divisor_cnt !== 8'(127 - k)) begin
          n_err++;
          $display("FAIL hist_sel%0d[%0d]: got q=%0b h=%b v=%0h, want q=%0b h=0101 v=%0h",
                   taps[t], k, quotient, dut.hist, divisor_cnt, want[t], 127 - k);
        end
      end
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'($urandom), 2'($urandom), 1'b1, 1'($urandom));
      if (k == 126 || k == 127 || k == 200) begin
        n_vec++;
        if (dividend_cnt !== ((k == 126) ? 8'hFE : 8'hFF)) begin
          n_err++;
          $display("FAIL sat_up[%0d]: got %0h want %0h", k, dividend_cnt,
                   (k == 126) ? 8'hFE : 8'hFF);
        end
      end
    end
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'($urandom), 2'($urandom), 1'b0, 1'($urandom));
      if (k == 254 || k == 255 || k == 300) begin
        n_vec++;
        if (dividend_cnt !== ((k == 254) ? 8'h01 : 8'h00)) begin
          n_err++;
          $display("FAIL sat_down[%0d]: got %0h want %0h", k, dividend_cnt,
                   (k == 254) ? 8'h01 : 8'h00);
        end
      end
    end
    n_vec++;
    if (quotient !== m_q || divisor_cnt !== 8'(m_vcnt) || dut.hist !== m_hist) begin
      n_err++;
      $display("FAIL sat_model: got q=%0b v=%0h h=%b, want q=%0b v=%0h h=%b",
               quotient, divisor_cnt, dut.hist, m_q, m_vcnt, m_hist);
    end
  endtask

  task automatic test_clear_vs_enable();
    for (int k = 0; k < 60; k++)
      step(1'b1, 1'b0, 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'b1);
    step(1'b0, 1'b1, 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    n_vec++;
    if (quotient !== 1'b0 || dividend_cnt !== 8'h80 || divisor_cnt !== 8'h80 ||
        dut.hist !== 4'b0101) begin
      n_err++;
      $display("FAIL clear_no_en: got q=%0b d=%0h v=%0h h=%b, want 0 80 80 0101",
               quotient, dividend_cnt, divisor_cnt, dut.hist);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0), 1'($urandom),
           8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      n_vec++;
      if (quotient !== m_q || dividend_cnt !== 8'(m_dcnt) || divisor_cnt !== 8'(m_vcnt) ||
          dut.hist !== m_hist) begin
        n_err++;
        $display("FAIL random[%0d]: got q=%0b d=%0h v=%0h h=%b, want q=%0b d=%0h v=%0h h=%b",
                 k, quotient, dividend_cnt, divisor_cnt, dut.hist,
                 m_q, m_dcnt, m_vcnt, m_hist);
      end
    end
  endtask

  // Regenerated streams with LFSR randnum: DUT must track the model exactly
  task automatic test_stat_regen();
    logic [7:0] lfsr = 8'h01;
    int ones_dut = 0, ones_ref = 0, bad = 0;
    step(1'b1, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4096; k++) begin
      step(1'b1, 1'b0, 1'b1, lfsr, 2'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)));
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      ones_dut += int'(quotient);
      ones_ref += int'(m_q);
      if (quotient !== m_q || dividend_cnt !== 8'(m_dcnt) || divisor_cnt !== 8'(m_vcnt))
        bad++;
    end
    n_vec++;
    if (bad != 0 || ones_dut != ones_ref) begin
      n_err++;
      $display("FAIL stat_regen: %0d cycle mismatches, ones got %0d want %0d",
               bad, ones_dut, ones_ref);
    end
  endtask

  // Correlated input streams, bypass path, both parameter sets: mean ~0.5
  task automatic test_stat_mean();
    int ones1 = 0, ones2 = 0;
    int r;
    real m1, m2;
    step(1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    en2 = 1'b1; clr2 = 1'b0; regen_en2 = 1'b0;
    for (int k = 0; k < 4096; k++) begin
      r = int'($urandom_range(0, 255));
      dividend2 = (r < 64);
      divisor2  = (r < 128);
      randnum2  = 10'($urandom);
      sel2      = 3'($urandom);
      step(1'b1, 1'b0, 1'b0, 8'($urandom), 2'($urandom), r < 64, r < 128);
      ones1 += int'(quotient);
      ones2 += int'(quotient2);
    end
    en2 = 1'b0;
    m1 = real'(ones1) / 4096.0;
    m2 = real'(ones2) / 4096.0;
    n_vec++;
    if (m1 < 0.45 || m1 > 0.55) begin
      n_err++;
      $display("FAIL mean_d4_w8: got %f want 0.50 +/- 0.05", m1);
    end
    n_vec++;
    if (m2 < 0.45 || m2 > 0.55) begin
      n_err++;
      $display("FAIL mean_d8_w10: got %f want 0.50 +/- 0.05", m2);
    end
    n_vec++;
    if (quotient !== m_q || dut.hist !== m_hist) begin
      n_err++;
      $display("FAIL stat_mean_model: got q=%0b h=%b want q=%0b h=%b",
               quotient, dut.hist, m_q, m_hist);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; regen_en = 1'b0; randnum = '0; sel = '0;
    dividend = 1'b0; divisor = 1'b0;
    en2 = 1'b0; clr2 = 1'b0; regen_en2 = 1'b0; randnum2 = '0; sel2 = '0;
    dividend2 = 1'b0; divisor2 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_hist_sel();
    test_saturation();
    test_clear_vs_enable();
    test_random();
    test_stat_regen();
    test_stat_mean();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
